// File: rtl/ps2_pkg.sv
// ps2_pkg: constants and types shared by the PS/2 receive and transmit paths.
//   PS2_FRAME_BITS  bits per device-to-host frame (start, 8 data, parity, stop)
//   *_BIT           bit positions within a frame, in wire order (index 0 = first bit)
//   rx_state_e      receive FSM states
package ps2_pkg;

  localparam int PS2_FRAME_BITS = 11;
  localparam int START_BIT      = 0;
  localparam int DATA_LSB_BIT   = 1;
  localparam int DATA_MSB_BIT   = 8;
  localparam int PARITY_BIT     = 9;
  localparam int STOP_BIT       = 10;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RECV = 2'd1,
    DONE = 2'd2
  } rx_state_e;

  // PS/2 uses odd parity over data+parity; an even count of ones is an error.
  function automatic logic parity_bad(input logic [8:0] data_and_parity);
    return ~^data_and_parity;
  endfunction

endpackage

// File: rtl/ps2_line_filter.sv
// ps2_line_filter: 2-FF synchroniser, saturating glitch filter and falling-edge
// strobe for one raw PS/2 pad line.
//   clk, rst_n  system clock, asynchronous active-low reset
//   line_i      raw asynchronous pad input
//   line_o      filtered line; resets to 1 (idle bus)
//   fall_o      one-cycle strobe, aligned with line_o dropping 1->0
module ps2_line_filter #(
  parameter int FILTER_LEN = 8
) (
  input  logic clk,
  input  logic rst_n,
  input  logic line_i,
  output logic line_o,
  output logic fall_o
);

  localparam int CNT_W = (FILTER_LEN > 2) ? $clog2(FILTER_LEN) : 1;

  logic             sync1_q, sync_q;
  logic             filt_q, filt_d;
  logic             fall_q, fall_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;

  // Count consecutive synchronised samples that disagree with the filtered
  // output; flip on the FILTER_LEN-th one. Any agreeing sample restarts the run.
  always_comb begin
    filt_d = filt_q;
    fall_d = 1'b0;
    cnt_d  = '0;
    if (sync_q != filt_q) begin
      if (cnt_q == CNT_W'(FILTER_LEN - 1)) begin
        filt_d = sync_q;
        fall_d = filt_q;
      end else begin
        cnt_d = cnt_q + 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync1_q <= 1'b1;
      sync_q  <= 1'b1;
      filt_q  <= 1'b1;
      fall_q  <= 1'b0;
      cnt_q   <= '0;
    end else begin
      sync1_q <= line_i;
      sync_q  <= sync1_q;
      filt_q  <= filt_d;
      fall_q  <= fall_d;
      cnt_q   <= cnt_d;
    end
  end

  assign line_o = filt_q;
  assign fall_o = fall_q;

endmodule

// File: rtl/ps2_rx_deframer.sv
// ps2_rx_deframer: receives device-to-host PS/2 frames and presents each byte
// with a one-cycle valid strobe and error flags.
//   Clk, nReset  system clock, asynchronous active-low reset
//   PS2Clk/Data  raw pad inputs (asynchronous)
//   Inhibit      host transmitter owns the bus; line activity is ignored
//   RxData       last received byte
//   RxValid      one-cycle pulse: RxData/ParityErr/FrameErr just updated
//   ParityErr    last frame failed odd parity (held)
//   FrameErr     last frame had start!=0 or stop!=1 (held)
//   TimeoutErr   one-cycle pulse: frame aborted, clock stopped mid-frame
//   Busy         frame in progress
module ps2_rx_deframer
  import ps2_pkg::*;
#(
  parameter int FILTER_LEN     = 8,
  parameter int TIMEOUT_CYCLES = 5000
) (
  input  logic       Clk,
  input  logic       nReset,
  input  logic       PS2Clk,
  input  logic       PS2Data,
  input  logic       Inhibit,
  output logic [7:0] RxData,
  output logic       RxValid,
  output logic       ParityErr,
  output logic       FrameErr,
  output logic       TimeoutErr,
  output logic       Busy
);

  localparam int TCNT_W = $clog2(TIMEOUT_CYCLES);

  logic clk_fall, data_f, clk_f_unused, data_fall_unused;

  ps2_line_filter #(.FILTER_LEN(FILTER_LEN)) u_clk_filt (
    .clk(Clk), .rst_n(nReset), .line_i(PS2Clk), .line_o(clk_f_unused), .fall_o(clk_fall)
  );

  ps2_line_filter #(.FILTER_LEN(FILTER_LEN)) u_data_filt (
    .clk(Clk), .rst_n(nReset), .line_i(PS2Data), .line_o(data_f), .fall_o(data_fall_unused)
  );

  rx_state_e                   state_q, state_d;
  logic [3:0]                  bit_cnt_q, bit_cnt_d;
  logic [PS2_FRAME_BITS-1:0]   shreg_q, shreg_d, shifted;
  logic [TCNT_W-1:0]           tcnt_q, tcnt_d;
  logic [7:0]                  rx_data_q, rx_data_d;
  logic                        perr_q, perr_d, ferr_q, ferr_d;
  logic                        valid_q, valid_d, tout_q, tout_d, busy_q, busy_d;

  // Bits enter at the top and move down, so after a full frame index 0 holds
  // the first (start) bit and the indices match wire order.
  assign shifted = {data_f, shreg_q[PS2_FRAME_BITS-1:1]};

  always_comb begin
    state_d   = state_q;
    bit_cnt_d = bit_cnt_q;
    shreg_d   = shreg_q;
    tcnt_d    = tcnt_q;
    rx_data_d = rx_data_q;
    perr_d    = perr_q;
    ferr_d    = ferr_q;
    valid_d   = 1'b0;
    tout_d    = 1'b0;
    busy_d    = busy_q;
    case (state_q)
      IDLE: begin
        tcnt_d    = '0;
        bit_cnt_d = '0;
        busy_d    = 1'b0;
        if (clk_fall && !Inhibit) begin
          shreg_d   = shifted;
          bit_cnt_d = 4'd1;
          state_d   = RECV;
          busy_d    = 1'b1;
        end
      end
      RECV: begin
        // Priority: Inhibit beats an edge, an edge beats timeout expiry.
        if (Inhibit) begin
          state_d   = IDLE;
          bit_cnt_d = '0;
          tcnt_d    = '0;
          busy_d    = 1'b0;
        end else if (clk_fall) begin
          shreg_d   = shifted;
          bit_cnt_d = bit_cnt_q + 4'd1;
          tcnt_d    = '0;
          // Outputs are registered here so they are already valid in the
          // DONE cycle, alongside RxValid.
          if (bit_cnt_q == 4'(PS2_FRAME_BITS - 1)) begin
            state_d   = DONE;
            busy_d    = 1'b0;
            valid_d   = 1'b1;
            rx_data_d = shifted[DATA_MSB_BIT:DATA_LSB_BIT];
            perr_d    = parity_bad(shifted[PARITY_BIT:DATA_LSB_BIT]);
            ferr_d    = shifted[START_BIT] | ~shifted[STOP_BIT];
          end
        end else if (tcnt_q == TCNT_W'(TIMEOUT_CYCLES - 1)) begin
          state_d   = IDLE;
          bit_cnt_d = '0;
          tcnt_d    = '0;
          tout_d    = 1'b1;
          busy_d    = 1'b0;
        end else if (tcnt_q != '1) begin
          tcnt_d = tcnt_q + 1'b1;
        end
      end
      DONE: begin
        state_d   = IDLE;
        bit_cnt_d = '0;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge Clk or negedge nReset) begin
    if (!nReset) begin
      state_q   <= IDLE;
      bit_cnt_q <= '0;
      shreg_q   <= '0;
      tcnt_q    <= '0;
      rx_data_q <= '0;
      perr_q    <= 1'b0;
      ferr_q    <= 1'b0;
      valid_q   <= 1'b0;
      tout_q    <= 1'b0;
      busy_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      bit_cnt_q <= bit_cnt_d;
      shreg_q   <= shreg_d;
      tcnt_q    <= tcnt_d;
      rx_data_q <= rx_data_d;
      perr_q    <= perr_d;
      ferr_q    <= ferr_d;
      valid_q   <= valid_d;
      tout_q    <= tout_d;
      busy_q    <= busy_d;
    end
  end

  assign RxData     = rx_data_q;
  assign RxValid    = valid_q;
  assign ParityErr  = perr_q;
  assign FrameErr   = ferr_q;
  assign TimeoutErr = tout_q;
  assign Busy       = busy_q;

endmodule
